instr_mem_pipe: RTL and testbench
=================================

# instr_mem_pipe

Parametrised, synchronous instruction memory with a valid/ready request port, a valid/ready response port and a word-write program-load port. It is the successor to the combinational single-cycle instruction store. It serves pipelined fetch stages that tolerate a fixed read latency and may stall the response side. Accesses are checked for alignment and range, and each response carries a fault code instead of silently aliasing.

## Interface
- DATA_W, 32, instruction word width in bits
- DEPTH, 32, number of words; must be a power of two, ≥ 2
- ADDR_W, 32, byte-address width of request and write ports
- LAT, 1, read latency in cycles from acceptance to response; legal values 1 or 2

- clk_i  input  1  single clock; all logic on the rising edge
- rst_i  input  1  reset; synchronous, active-high
- req_valid_i  input  1  fetch request valid
- req_ready_o  output  1  request can be accepted this cycle
- req_addr_i  input  ADDR_W  byte address of the fetch
- resp_valid_o  output  1  response valid
- resp_ready_i  input  1  consumer accepts the response this cycle
- resp_instr_o  output  DATA_W  instruction word; 0 when faulted
- resp_fault_o  output  2  00 ok, 01 misaligned, 10 out of range
- wr_en_i  input  1  program-load write strobe
- wr_addr_i  input  ADDR_W  byte address of the write; bits [1:0] ignored
- wr_data_i  input  DATA_W  write data

## Operation
- Request handshake: a request is accepted on a rising edge where req_valid_i && req_ready_o. Word index = req_addr_i >> 2.
- Fault classification happens at acceptance. Misaligned takes priority:
  - req_addr_i[1:0] != 0 → fault 01, instr 0.
  - Otherwise, index ≥ DEPTH → fault 10, instr 0.
  - Otherwise, fault 00, instr = Mem[index].
- Outstanding count: requests accepted but not yet popped, covering both pipeline stages and the output buffer. Range 0..LAT+1.
- Output buffer: FIFO of LAT+1 entries holding completed responses. resp_* present its head. A pop happens on a rising edge where resp_valid_o && resp_ready_i.
- Ready rule: req_ready_o = !rst_i && (outstanding < LAT+1 || (resp_valid_o && resp_ready_i)). The same-cycle pop frees a slot, which sustains one request per cycle when resp_ready_i is held high.
- Ordering: responses emerge strictly in acceptance order. None are dropped or duplicated.
- Write port: on a rising edge with wr_en_i && !rst_i, Mem[wr_addr_i>>2] ← wr_data_i. Writes with index ≥ DEPTH are ignored.
- Read/write collision to the same word on the same edge: the read returns the old data (read-before-write).
- Memory contents are not cleared by reset. After power-up they are undefined until written; the bench loads them through the write port.

## Timing
- Reset (rst_i high at an edge) forces the following at that edge:
  - outstanding = 0; pipeline and FIFO are emptied.
  - resp_valid_o = 0, resp_instr_o = 0, resp_fault_o = 00.
  - req_ready_o is 0 while rst_i is high and 1 in the first cycle after release.
- Reset mid-operation discards all in-flight and buffered responses. Nothing is emitted for them afterwards.
- Latency: a request accepted at edge n gives resp_valid_o high from edge n+LAT, provided no older response is still buffered.
- Stall: while resp_valid_o && !resp_ready_i, resp_instr_o and resp_fault_o stay stable.
  - In-flight reads keep completing into the FIFO.
  - Acceptance stops once outstanding reaches LAT+1.
- Simultaneous accept and pop on the same edge leaves outstanding unchanged.
- Throughput: 1 response per cycle sustained with resp_ready_i = 1.
- Address wrap: no wrap-around. Indices ≥ DEPTH fault, they do not alias.

## Test plan
- Reset then load: write Mem[0..3] = 0x11111111, 0x22222222, 0x33333333, 0x44444444 via the write port. Fetch 0x0, 0x4, 0x8, 0xC back-to-back with resp_ready_i=1 → responses in the same order, LAT cycles after each accept, fault 00, req_ready_o never low.
- Faults: fetch 0x2 → fault 01, instr 0. Fetch DEPTH*4 (0x80 at default) → fault 10, instr 0. Fetch 0x7F → fault 01 (misaligned wins over out of range).
- Backpressure: hold resp_ready_i=0 and drive req_valid_i=1 continuously → exactly LAT+1 accepts, then req_ready_o=0 and the head stays stable. Release → LAT+1 in-order responses, then streaming resumes at 1 per cycle.
- Collision: Mem[5]=0xAAAAAAAA. On the same edge fetch 0x14 and write 0xBBBBBBBB to 0x14 → response 0xAAAAAAAA. A following fetch of 0x14 → 0xBBBBBBBB.
- Reset mid-stream: with 2 responses outstanding, assert rst_i for one edge → resp_valid_o=0 and no stale responses later. Memory still holds the loaded values, so a fetch of 0x0 returns 0x11111111.
- Parameter sweep: repeat the first and third scenarios with LAT=2 and DEPTH=64. Also write to 0x100 (index 64) and check that it is ignored and a fetch of 0x100 returns fault 10.

Source files
------------

// File: rtl/instr_mem_pipe.sv
// instr_mem_pipe
//   Synchronous instruction memory with a fixed read latency. Requests are
//   checked for alignment and range when accepted. Completed responses queue in
//   a small output FIFO so the consumer can stall without losing data.
//
// Ports
//   clk_i         rising-edge clock
//   rst_i         synchronous active-high reset (memory contents are kept)
//   req_valid_i   fetch request valid
//   req_ready_o   request accepted this cycle when high together with valid
//   req_addr_i    fetch byte address
//   resp_valid_o  response valid (head of the output FIFO)
//   resp_ready_i  consumer takes the head this cycle
//   resp_instr_o  instruction word, 0 when faulted or empty
//   resp_fault_o  00 ok, 01 misaligned, 10 out of range
//   wr_en_i       program-load write strobe
//   wr_addr_i     write byte address, bits [1:0] ignored
//   wr_data_i     write data
module instr_mem_pipe #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned DEPTH  = 32,
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned LAT    = 1
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              req_valid_i,
   output logic              req_ready_o,
   input  logic [ADDR_W-1:0] req_addr_i,
   output logic              resp_valid_o,
   input  logic              resp_ready_i,
   output logic [DATA_W-1:0] resp_instr_o,
   output logic [1:0]        resp_fault_o,
   input  logic              wr_en_i,
   input  logic [ADDR_W-1:0] wr_addr_i,
   input  logic [DATA_W-1:0] wr_data_i
);

   localparam int unsigned IDX_W = $clog2(DEPTH);
   localparam int unsigned FD    = LAT + 1;        // output FIFO entries
   localparam int unsigned PW    = $clog2(FD);     // FIFO pointer width
   localparam int unsigned CW    = $clog2(FD + 1); // counts 0..FD

   logic [DATA_W-1:0] r_mem [DEPTH];

   // Read pipeline: one stage per cycle of latency
   logic [LAT-1:0]    r_stg_vld;
   logic [DATA_W-1:0] r_stg_instr [LAT];
   logic [1:0]        r_stg_fault [LAT];

   // Output FIFO
   logic [DATA_W-1:0] r_fifo_instr [FD];
   logic [1:0]        r_fifo_fault [FD];
   logic [PW-1:0]     r_rd_ptr;
   logic [PW-1:0]     r_wr_ptr;
   logic [CW-1:0]     r_fifo_cnt;

   // Requests accepted but not yet popped (pipeline + FIFO)
   logic [CW-1:0]     r_outst;

   logic [ADDR_W-3:0] w_req_word;
   logic [IDX_W-1:0]  w_req_idx;
   logic              w_req_misal;
   logic              w_req_oor;
   logic [1:0]        w_req_fault;
   logic [ADDR_W-3:0] w_wr_word;
   logic [IDX_W-1:0]  w_wr_idx;
   logic              w_wr_oor;
   logic              w_accept;
   logic              w_pop;
   logic              w_push;
   logic              w_unused;

   function automatic logic [PW-1:0] f_next_ptr(input logic [PW-1:0] p);
      return (p == PW'(FD - 1)) ? '0 : p + 1'b1;
   endfunction

   // Full-width compare so indices past DEPTH fault instead of aliasing
   assign w_req_word  = req_addr_i[ADDR_W-1:2];
   assign w_req_idx   = w_req_word[IDX_W-1:0];
   assign w_req_misal = |req_addr_i[1:0];
   assign w_req_oor   = w_req_word >= (ADDR_W-2)'(DEPTH);
   assign w_req_fault = w_req_misal ? 2'b01 : (w_req_oor ? 2'b10 : 2'b00);

   assign w_wr_word = wr_addr_i[ADDR_W-1:2];
   assign w_wr_idx  = w_wr_word[IDX_W-1:0];
   assign w_wr_oor  = w_wr_word >= (ADDR_W-2)'(DEPTH);
   assign w_unused  = ^wr_addr_i[1:0];

   assign resp_valid_o = (r_fifo_cnt != '0);
   assign resp_instr_o = resp_valid_o ? r_fifo_instr[r_rd_ptr] : '0;
   assign resp_fault_o = resp_valid_o ? r_fifo_fault[r_rd_ptr] : 2'b00;

   assign w_pop    = resp_valid_o && resp_ready_i;
   // A same-cycle pop frees a slot, keeping one request per cycle when streaming
   assign req_ready_o = !rst_i && ((r_outst < CW'(FD)) || w_pop);
   assign w_accept = req_valid_i && req_ready_o;
   assign w_push   = r_stg_vld[LAT-1];

   // Memory is not reset; the read in the stage register below sees the old
   // word when a write hits the same index on the same edge.
   always_ff @(posedge clk_i) begin
      if (wr_en_i && !rst_i && !w_wr_oor) begin
         r_mem[w_wr_idx] <= wr_data_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_stg_vld <= '0;
         for (int k = 0; k < LAT; k++) begin
            r_stg_instr[k] <= '0;
            r_stg_fault[k] <= 2'b00;
         end
      end else begin
         r_stg_vld[0]   <= w_accept;
         r_stg_instr[0] <= (w_req_fault == 2'b00) ? r_mem[w_req_idx] : '0;
         r_stg_fault[0] <= w_req_fault;
         for (int k = 1; k < LAT; k++) begin
            r_stg_vld[k]   <= r_stg_vld[k-1];
            r_stg_instr[k] <= r_stg_instr[k-1];
            r_stg_fault[k] <= r_stg_fault[k-1];
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_rd_ptr   <= '0;
         r_wr_ptr   <= '0;
         r_fifo_cnt <= '0;
      end else begin
         if (w_push) begin
            r_fifo_instr[r_wr_ptr] <= r_stg_instr[LAT-1];
            r_fifo_fault[r_wr_ptr] <= r_stg_fault[LAT-1];
            r_wr_ptr               <= f_next_ptr(r_wr_ptr);
         end
         if (w_pop) begin
            r_rd_ptr <= f_next_ptr(r_rd_ptr);
         end
         if (w_push && !w_pop) begin
            r_fifo_cnt <= r_fifo_cnt + CW'(1);
         end else if (!w_push && w_pop) begin
            r_fifo_cnt <= r_fifo_cnt - CW'(1);
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_outst <= '0;
      end else if (w_accept && !w_pop) begin
         r_outst <= r_outst + CW'(1);
      end else if (!w_accept && w_pop) begin
         r_outst <= r_outst - CW'(1);
      end
   end

endmodule

// File: tb/tb_instr_mem_pipe.sv
// Bench for instr_mem_pipe. Two instances share one stimulus stream:
// dut 0 uses LAT=1/DEPTH=32, dut 1 uses LAT=2/DEPTH=64. A queue model per
// instance predicts valid/ready/head every cycle; logged pops are also pinned
// against hand-computed literals.
module tb_instr_mem_pipe;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, req_valid, resp_ready, wr_en;
   logic [31:0] req_addr, wr_addr, wr_data;
   logic [1:0]        rr, rv;
   logic [1:0][31:0]  ri;
   logic [1:0][1:0]   rf;

   instr_mem_pipe #(.DATA_W(32), .DEPTH(32), .ADDR_W(32), .LAT(1)) u_dut0 (
      .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_ready_o(rr[0]),
      .req_addr_i(req_addr), .resp_valid_o(rv[0]), .resp_ready_i(resp_ready),
      .resp_instr_o(ri[0]), .resp_fault_o(rf[0]), .wr_en_i(wr_en),
      .wr_addr_i(wr_addr), .wr_data_i(wr_data)
   );

   instr_mem_pipe #(.DATA_W(32), .DEPTH(64), .ADDR_W(32), .LAT(2)) u_dut1 (
      .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_ready_o(rr[1]),
      .req_addr_i(req_addr), .resp_valid_o(rv[1]), .resp_ready_i(resp_ready),
      .resp_instr_o(ri[1]), .resp_fault_o(rf[1]), .wr_en_i(wr_en),
      .wr_addr_i(wr_addr), .wr_data_i(wr_data)
   );

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   // Model state per instance: queue of {fault, instr} with accept cycle
   logic [33:0] mq   [2][8];
   int          macc [2][8];
   int          mh   [2];
   int          cnt  [2];
   logic [31:0] mm   [2][64];
   logic [33:0] plog [2][64];
   int          pn   [2];
   bit          post_rst [2];
   int          base [2];

   logic [31:0] fa   [6] = '{32'h2, 32'h80, 32'h7F, 32'h81, 32'h100, 32'h0};
   logic [33:0] fe0  [6] = '{{2'b01, 32'h0}, {2'b10, 32'h0}, {2'b01, 32'h0},
                             {2'b01, 32'h0}, {2'b10, 32'h0}, {2'b00, 32'h11111111}};
   logic [33:0] fe1  [6] = '{{2'b01, 32'h0}, {2'b00, 32'h32323232}, {2'b01, 32'h0},
                             {2'b01, 32'h0}, {2'b10, 32'h0}, {2'b00, 32'h11111111}};

   task automatic chk(input string name, input int d, input logic [33:0] act,
                      input logic [33:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s dut%0d cyc %0d: got %h expected %h", name, d, cyc, act, exp);
      end
   endtask

   // Compare outputs with the model, then apply the coming edge to the model
   task automatic model_step();
      for (int d = 0; d < 2; d++) begin
         int lat = (d == 0) ? 1 : 2;
         int dep = (d == 0) ? 32 : 64;
         int idx;
         bit vexp, rexp;
         logic [33:0] ent;
         vexp = (cnt[d] > 0) && (macc[d][mh[d]] + lat <= cyc);
         rexp = !rst && ((cnt[d] < lat + 1) || (vexp && resp_ready));
         chk("resp_valid", d, {33'd0, rv[d]}, {33'd0, vexp});
         chk("req_ready", d, {33'd0, rr[d]}, {33'd0, rexp});
         if (vexp) begin
            chk("resp_head", d, {rf[d], ri[d]}, mq[d][mh[d]]);
         end else if (post_rst[d]) begin
            chk("resp_after_rst", d, {rf[d], ri[d]}, 34'd0);
         end
         if (rst) begin
            cnt[d] = 0;
            mh[d]  = 0;
         end else begin
            if (vexp && resp_ready) begin
               if (pn[d] < 64) plog[d][pn[d]] = mq[d][mh[d]];
               pn[d]++;
               mh[d] = (mh[d] + 1) % 8;
               cnt[d]--;
            end
            if (req_valid && rexp) begin
               idx = int'(req_addr >> 2);
               if (req_addr[1:0] != 2'b00) ent = {2'b01, 32'h0};
               else if (idx >= dep)        ent = {2'b10, 32'h0};
               else                        ent = {2'b00, mm[d][idx]};
               mq[d][(mh[d] + cnt[d]) % 8]   = ent;
               macc[d][(mh[d] + cnt[d]) % 8] = cyc + 1;
               cnt[d]++;
            end
            idx = int'(wr_addr >> 2);
            if (wr_en && idx < dep) mm[d][idx] = wr_data;
         end
         post_rst[d] = rst;
      end
      cyc++;
   endtask

   task automatic tick();
      @(negedge clk);
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic mark();
      base[0] = pn[0];
      base[1] = pn[1];
   endtask

   initial begin
      rst = 1'b1; req_valid = 1'b0; resp_ready = 1'b0; wr_en = 1'b0;
      req_addr = '0; wr_addr = '0; wr_data = '0;
      for (int d = 0; d < 2; d++) begin
         mh[d] = 0; cnt[d] = 0; pn[d] = 0; post_rst[d] = 1'b0;
      end
      @(posedge clk);
      #1;
      tick();
      tick();
      chk("ready_in_reset", 0, {32'd0, rr}, 34'd0);
      rst = 1'b0;
      tick();
      chk("ready_after_release", 0, {32'd0, rr}, {32'd0, 2'b11});

      // Program load
      wr_en = 1'b1;
      for (int i = 0; i < 4; i++) begin
         wr_addr = 32'(4 * i);
         wr_data = 32'h11111111 * 32'(i + 1);
         tick();
      end
      wr_addr = 32'h14;  wr_data = 32'hAAAAAAAA; tick();
      wr_addr = 32'h80;  wr_data = 32'h32323232; tick();
      wr_addr = 32'h100; wr_data = 32'hDEADBEEF; tick();
      wr_en = 1'b0;

      // Back-to-back stream
      mark();
      resp_ready = 1'b1;
      req_valid  = 1'b1;
      for (int i = 0; i < 4; i++) begin
         req_addr = 32'(4 * i);
         tick();
      end
      req_valid = 1'b0;
      repeat (4) tick();
      for (int d = 0; d < 2; d++) begin
         chk("stream_count", d, 34'(pn[d] - base[d]), 34'd4);
         for (int i = 0; i < 4; i++)
            chk("stream_data", d, plog[d][base[d] + i], {2'b00, 32'h11111111 * 32'(i + 1)});
      end

      // Faults, range and ignored out-of-range write
      mark();
      req_valid = 1'b1;
      for (int i = 0; i < 6; i++) begin
         req_addr = fa[i];
         tick();
      end
      req_valid = 1'b0;
      repeat (4) tick();
      for (int i = 0; i < 6; i++) begin
         chk("fault_d0", 0, plog[0][base[0] + i], fe0[i]);
         chk("fault_d1", 1, plog[1][base[1] + i], fe1[i]);
      end

      // Backpressure
      mark();
      resp_ready = 1'b0;
      req_valid  = 1'b1;
      for (int i = 0; i < 8; i++) begin
         req_addr = 32'(4 * (i % 4));
         tick();
      end
      chk("stall_ready", 0, {32'd0, rr}, 34'd0);
      chk("stall_nopop", 0, 34'(pn[0] - base[0]), 34'd0);
      resp_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         req_addr = 32'(4 * (i % 4));
         tick();
      end
      req_valid = 1'b0;
      repeat (5) tick();
      chk("bp_first0", 0, plog[0][base[0]],     {2'b00, 32'h11111111});
      chk("bp_second0", 0, plog[0][base[0] + 1], {2'b00, 32'h22222222});
      chk("bp_third1", 1, plog[1][base[1] + 2],  {2'b00, 32'h33333333});
      chk("bp_total0", 0, 34'(pn[0] - base[0]), 34'd8);
      chk("bp_total1", 1, 34'(pn[1] - base[1]), 34'd9);

      // Read-before-write collision
      mark();
      req_valid = 1'b1; req_addr = 32'h14;
      wr_en = 1'b1; wr_addr = 32'h14; wr_data = 32'hBBBBBBBB;
      tick();
      wr_en = 1'b0; req_valid = 1'b0;
      tick();
      req_valid = 1'b1;
      tick();
      req_valid = 1'b0;
      repeat (4) tick();
      for (int d = 0; d < 2; d++) begin
         chk("collide_old", d, plog[d][base[d]],     {2'b00, 32'hAAAAAAAA});
         chk("collide_new", d, plog[d][base[d] + 1], {2'b00, 32'hBBBBBBBB});
      end

      // Reset with two responses outstanding
      resp_ready = 1'b0;
      req_valid  = 1'b1; req_addr = 32'h8;
      tick();
      tick();
      req_valid = 1'b0;
      tick();
      mark();
      rst = 1'b1;
      tick();
      chk("rst_valid", 0, {32'd0, rv}, 34'd0);
      rst = 1'b0;
      resp_ready = 1'b1;
      repeat (4) tick();
      chk("rst_nostale0", 0, 34'(pn[0] - base[0]), 34'd0);
      chk("rst_nostale1", 1, 34'(pn[1] - base[1]), 34'd0);
      req_valid = 1'b1; req_addr = 32'h0;
      tick();
      req_valid = 1'b0;
      repeat (4) tick();
      for (int d = 0; d < 2; d++)
         chk("rst_mem_kept", d, plog[d][base[d]], {2'b00, 32'h11111111});

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
